// File: rtl/cpu_loader_pkg.sv
// cpu_loader_pkg
// Shared definitions for the program loader: FSM state encoding, header
// field positions and the maximum frame length.
package cpu_loader_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_HDR     = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RELEASE = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    // Header word layout
    localparam int HDR_TGT     = 15;  // 0 = imem, 1 = dmem
    localparam int HDR_LAST    = 14;  // final frame of the program
    localparam int HDR_LEN_HI  = 13;  // len_m1 field
    localparam int HDR_LEN_LO  = 8;
    localparam int HDR_BASE_HI = 7;   // base address field
    localparam int HDR_BASE_LO = 0;

    localparam int MAX_LEN = 64;
    localparam int LEN_W   = $clog2(MAX_LEN);

endpackage

// File: rtl/cpu_loader.sv
// cpu_loader
// Program loader in front of Single_Cycle_CPU. Accepts framed 16-bit words
// over valid/ready, writes payload into imem/dmem via the ex_* ports, then
// releases the CPU from reset, counts run cycles until flag_done (or a
// timeout), and puts the CPU back in reset.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   s_valid/s_ready/s_data word stream (header or payload)
//   ex_iwe/iaddr/idata     imem write port
//   ex_dwe/daddr/ddata     dmem write port
//   cpu_rst_n              CPU reset, low = held in reset
//   flag_done              CPU halted
//   busy                   any state other than HDR
//   done                   one-cycle pulse at end of a successful run
//   err                    sticky timeout flag, cleared by the next header
//   run_cycles             cycles of the last run, saturating
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        ex_iwe,
    output logic [7:0]  ex_iaddr,
    output logic [15:0] ex_idata,
    output logic        ex_dwe,
    output logic [7:0]  ex_daddr,
    output logic [15:0] ex_ddata,
    output logic        cpu_rst_n,
    input  logic        flag_done,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] run_cycles
);

    logic [2:0]       state, state_nx;
    logic             tgt, last;
    logic [LEN_W-1:0] cnt;
    logic [7:0]       addr;
    logic             acc;
    logic             timeout_hit;

    assign acc         = s_valid && s_ready;
    // flag_done wins over the timeout when both land on the same edge
    assign timeout_hit = !flag_done && (run_cycles == TIMEOUT - 16'd1);

    assign busy      = (state != ST_HDR);
    assign cpu_rst_n = (state == ST_RUN);
    assign done      = (state == ST_FINISH) && !err;

    always_comb begin
        state_nx = state;
        case (state)
            ST_HDR:     if (acc) state_nx = ST_LOAD;
            ST_LOAD:    if (acc && cnt == '0) state_nx = last ? ST_RELEASE : ST_HDR;
            ST_RELEASE: state_nx = ST_RUN;
            ST_RUN:     if (flag_done || timeout_hit) state_nx = ST_FINISH;
            ST_FINISH:  state_nx = ST_HDR;
            default:    state_nx = ST_HDR;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_HDR;
            s_ready    <= 1'b0;
            tgt        <= 1'b0;
            last       <= 1'b0;
            cnt        <= '0;
            addr       <= '0;
            ex_iwe     <= 1'b0;
            ex_iaddr   <= '0;
            ex_idata   <= '0;
            ex_dwe     <= 1'b0;
            ex_daddr   <= '0;
            ex_ddata   <= '0;
            err        <= 1'b0;
            run_cycles <= '0;
        end else begin
            state   <= state_nx;
            // Registered from the next state, so it tracks the current state
            // except for the first cycle out of reset, where it stays low.
            s_ready <= (state_nx == ST_HDR) || (state_nx == ST_LOAD);
            ex_iwe  <= 1'b0;
            ex_dwe  <= 1'b0;
            case (state)
                ST_HDR: if (acc) begin
                    tgt  <= s_data[HDR_TGT];
                    last <= s_data[HDR_LAST];
                    cnt  <= s_data[HDR_LEN_HI:HDR_LEN_LO];
                    addr <= s_data[HDR_BASE_HI:HDR_BASE_LO];
                    err  <= 1'b0;
                end
                ST_LOAD: if (acc) begin
                    addr <= addr + 8'd1;   // wraps FFh -> 00h
                    cnt  <= cnt - 1'b1;
                    if (tgt) begin
                        ex_dwe   <= 1'b1;
                        ex_daddr <= addr;
                        ex_ddata <= s_data;
                    end else begin
                        ex_iwe   <= 1'b1;
                        ex_iaddr <= addr;
                        ex_idata <= s_data;
                    end
                end
                ST_RELEASE: run_cycles <= '0;
                ST_RUN: begin
                    if (run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
                    if (timeout_hit) err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_loader.sv
// Scoreboard bench for cpu_loader: drivers push expected memory writes and
// expected run outcomes into queues; independent monitors pop and compare
// whenever the DUT shows a write strobe or ends a run.
module tb_cpu_loader;

    localparam logic [15:0] TMO = 16'd20;

    logic        clk_i = 1'b0;
    logic        rst_i, s_valid, flag_done;
    logic [15:0] s_data;
    logic        s_ready, ex_iwe, ex_dwe, cpu_rst_n, busy, done, err;
    logic [7:0]  ex_iaddr, ex_daddr;
    logic [15:0] ex_idata, ex_ddata, run_cycles;

    cpu_loader #(.TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .ex_iwe(ex_iwe), .ex_iaddr(ex_iaddr), .ex_idata(ex_idata),
        .ex_dwe(ex_dwe), .ex_daddr(ex_daddr), .ex_ddata(ex_ddata),
        .cpu_rst_n(cpu_rst_n), .flag_done(flag_done), .busy(busy), .done(done),
        .err(err), .run_cycles(run_cycles)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic tgt; logic [7:0] addr; logic [15:0] data; } wr_t;
    typedef struct packed { logic done; logic err; logic [15:0] rc; } run_t;

    wr_t  wq[$];
    run_t rq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- monitors ----------------
    wr_t  we;
    always @(negedge clk_i) begin
        if (ex_iwe || ex_dwe) begin
            if (wq.size() == 0) chk("unexpected_strobe", {30'd0, ex_iwe, ex_dwe}, 32'd0);
            else begin
                we = wq.pop_front();
                chk("wr_strobe", {30'd0, ex_iwe, ex_dwe}, we.tgt ? 32'd1 : 32'd2);
                chk("wr_addr", we.tgt ? ex_daddr : ex_iaddr, we.addr);
                chk("wr_data", we.tgt ? ex_ddata : ex_idata, we.data);
            end
        end
    end

    run_t re;
    logic prev_crn = 1'b0;
    always @(negedge clk_i) begin
        if (prev_crn && !cpu_rst_n) begin
            if (rq.size() == 0) chk("unexpected_run_end", 32'd1, 32'd0);
            else begin
                re = rq.pop_front();
                chk("end_done", done, re.done);
                chk("end_err", err, re.err);
                chk("end_run_cycles", run_cycles, re.rc);
                chk("end_s_ready", s_ready, 32'd0);
            end
        end else if (done) chk("stray_done", done, 32'd0);
        if (cpu_rst_n) chk("s_ready_in_run", s_ready, 32'd0);
        prev_crn = cpu_rst_n;
    end

    // ---------------- driver ----------------
    task automatic send(input logic [15:0] d, input bit is_pl, input bit tgt, input logic [7:0] a);
        int  n = 0;
        wr_t e;
        s_valid = 1'b1;
        s_data  = d;
        while (!s_ready && n < 50) begin @(negedge clk_i); n++; end
        if (!s_ready) begin
            chk("s_ready_wait", s_ready, 32'd1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk_i);
        if (is_pl) begin e.tgt = tgt; e.addr = a; e.data = d; wq.push_back(e); end
        @(negedge clk_i);
        s_valid = 1'b0;
        s_data  = 16'($urandom);
    endtask

    task automatic send_frame(input bit tgt, input bit last, input logic [7:0] base,
                              input logic [15:0] pl[$], input bit gaps);
        logic [15:0] h;
        h = {tgt, last, 6'(pl.size() - 1), base};
        send(h, 1'b0, 1'b0, 8'd0);
        foreach (pl[i]) begin
            if (gaps) @(negedge clk_i);   // one idle cycle with s_valid low
            send(pl[i], 1'b1, tgt, base + 8'(i));
        end
    endtask

    // Called at the negedge of the RELEASE cycle. k = RUN cycle in which
    // flag_done is raised (k > TMO means never within the timeout window).
    task automatic run_to_end(input int k);
        run_t r;
        int   c = 1;
        chk("release_crn", cpu_rst_n, 32'd0);
        chk("release_ready", s_ready, 32'd0);
        chk("release_busy", busy, 32'd1);
        if (k <= int'(TMO)) begin r.done = 1'b1; r.err = 1'b0; r.rc = 16'(k); end
        else                begin r.done = 1'b0; r.err = 1'b1; r.rc = TMO;    end
        rq.push_back(r);
        @(negedge clk_i);
        chk("run_crn_rise", cpu_rst_n, 32'd1);
        while (cpu_rst_n && c < 200) begin
            flag_done = (c == k);
            @(negedge clk_i);
            c++;
        end
        flag_done = 1'b0;
        chk("run_ended", cpu_rst_n, 32'd0);
    endtask

    logic [15:0] pl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; s_valid = 1'b0; s_data = '0; flag_done = 1'b0;
        @(negedge clk_i); @(negedge clk_i);
        chk("rst_ctrl", {s_ready, ex_iwe, ex_dwe, cpu_rst_n, busy, done, err}, 32'd0);
        chk("rst_run_cycles", run_cycles, 32'd0);
        chk("rst_addrs", {ex_iaddr, ex_daddr}, 32'd0);
        chk("rst_data", {ex_idata, ex_ddata}, 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("s_ready_after_rst", s_ready, 32'd1);

        // Full program from the reference sequence
        pl = '{16'h1025, 16'h1900, 16'h1901};
        send_frame(1'b0, 1'b0, 8'h00, pl, 1'b0);
        pl = '{16'h0020, 16'h0010};
        send_frame(1'b1, 1'b1, 8'h25, pl, 1'b0);
        run_to_end(12);
        @(negedge clk_i);
        chk("post_run_ready", s_ready, 32'd1);
        chk("post_run_busy", busy, 32'd0);

        // Backpressure: idle cycle before each payload word
        pl = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
        send_frame(1'b1, 1'b1, 8'h80, pl, 1'b1);
        run_to_end(3);
        @(negedge clk_i);

        // Address wrap, not last: back to HDR with CPU still in reset
        pl = '{16'h0F0E, 16'h0F0F, 16'h0F00, 16'h0F01};
        send_frame(1'b0, 1'b0, 8'hFE, pl, 1'b0);
        chk("wrap_crn", cpu_rst_n, 32'd0);
        chk("wrap_busy", busy, 32'd0);
        chk("wrap_ready", s_ready, 32'd1);

        // Timeout: flag_done never raised
        pl = '{16'h5555};
        send_frame(1'b0, 1'b1, 8'h10, pl, 1'b0);
        run_to_end(1000);
        @(negedge clk_i);
        chk("err_sticky", err, 32'd1);
        send({1'b1, 1'b0, 6'd0, 8'h30}, 1'b0, 1'b0, 8'd0);
        chk("err_cleared", err, 32'd0);
        send(16'h7777, 1'b1, 1'b1, 8'h30);

        // Reset after the 2nd payload of a len-4 frame
        send({1'b0, 1'b0, 6'd3, 8'h40}, 1'b0, 1'b0, 8'd0);
        send(16'hC001, 1'b1, 1'b0, 8'h40);
        send(16'hC002, 1'b1, 1'b0, 8'h41);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("midrst_strobes", {ex_iwe, ex_dwe}, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_crn", cpu_rst_n, 32'd0);
        // Next word must be taken as a header (dmem, base 90h)
        pl = '{16'hBEEF};
        send_frame(1'b1, 1'b0, 8'h90, pl, 1'b0);

        // Reset during RUN
        pl = '{16'h1234};
        send_frame(1'b0, 1'b1, 8'h20, pl, 1'b0);
        rq.push_back(run_t'{done: 1'b0, err: 1'b0, rc: 16'd0});
        @(negedge clk_i); @(negedge clk_i); @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk("runrst_crn", cpu_rst_n, 32'd0);
        @(negedge clk_i);

        // Randomized programs
        repeat (8) begin
            int nf;
            nf = $urandom_range(1, 3);
            for (int f = 0; f < nf; f++) begin
                int len;
                len = $urandom_range(1, 6);
                pl.delete();
                for (int i = 0; i < len; i++) pl.push_back(16'($urandom));
                send_frame(1'($urandom), (f == nf - 1), 8'($urandom), pl, 1'($urandom));
            end
            run_to_end($urandom_range(1, 26));
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
        end

        repeat (3) @(negedge clk_i);
        chk("wq_empty", wq.size(), 32'd0);
        chk("rq_empty", rq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
